key_tx_queue: RTL and testbench
===============================

Name: key_tx_queue

Overview:
Buffered byte source for the UART transmitter. Accepts PS2 scancodes (make codes only: break sequences filtered, extended prefix optionally kept) and switch bytes loaded by a button pulse. Merges both into a DEPTH-entry FIFO and drains it to the UART TX through a start/busy handshake. Exposes last key, fill level and a sticky overflow flag for the seven-segment/LED status display.

Parameters:
DATA_W, 8, byte width of scancodes, switch input and TX data
DEPTH, 16, FIFO entries; power of two, >=2
BREAK_CODE, 8'hF0, PS2 break prefix; it and the following byte are discarded
EXT_CODE, 8'hE0, PS2 extended prefix
KEEP_EXT, 0, 1: EXT_CODE bytes are queued; 0: EXT_CODE bytes are dropped
ACK_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start before treating the byte as sent

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scancode  in  DATA_W  PS2 byte, valid when new_code=1
new_code  in  1  one-cycle strobe per received PS2 byte
sw  in  DATA_W  switch byte
load_sw  in  1  one-cycle pulse (already single-pulsed) to queue sw
tx_busy  in  1  UART transmitter busy
tx_data  out  DATA_W  byte presented to UART; held stable from tx_start until byte completes
tx_start  out  1  one-cycle send request
last_key  out  DATA_W  most recent accepted make code
fifo_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a byte was dropped because FIFO was full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_count=0, tx_start=0, tx_data=0, last_key=0, overflow=0, break-skip flag=0, sw pending=0, FSM=IDLE.
- PS2 filter, on new_code=1:
  - scancode==BREAK_CODE: set skip flag; byte not queued.
  - else if skip=1: clear skip; byte not queued and last_key unchanged.
  - else if scancode==EXT_CODE and KEEP_EXT=0: dropped; skip unaffected.
  - else: accepted; last_key<=scancode next cycle; write request.
- Switch path: load_sw=1 latches sw into a pending register and sets pending. Pending is written on the first cycle with no key write request; a key write wins on collisions. A load_sw while pending=1 overwrites the pending value.
- FIFO: single write port, single read port. Write and read in the same cycle: count unchanged; this is legal when full. Write when full with no read in the same cycle: byte dropped, overflow<=1. A cleared pending switch byte counts as consumed even when dropped. Pointers wrap modulo DEPTH. clr_ovf and a new overflow in the same cycle: overflow=1.
- TX FSM:
  - IDLE: if FIFO non-empty and tx_busy=0, pop the head into tx_data, assert tx_start for exactly 1 cycle, go to ACK. Latency from first write into an empty FIFO to tx_start is 2 cycles.
  - ACK: wait for tx_busy=1, then go to DONE. If ACK_TIMEOUT cycles elapse without tx_busy, go to IDLE (byte counted as sent).
  - DONE: wait for tx_busy=0, then go to IDLE.
  - tx_data changes only on a pop.
  - Back-to-back bytes: at least 1 IDLE cycle between a tx_busy fall and the next tx_start.
- Mid-operation reset: all state returns to reset values immediately; any in-flight byte and queued bytes are lost.
- fifo_count reflects the occupancy registered at the end of the previous cycle.

Test Plan:
- Make/break filtering: new_code strobes with 1C, F0, 1C, then 32 (the busy model is 10 cycles) -> tx_start twice, tx_data=1C then 32; last_key=32; fifo_count returns to 0.
- Extended prefix: E0, 75, E0, F0, 75 with KEEP_EXT=0 -> only 75 is sent. Same sequence with KEEP_EXT=1 -> E0, 75, E0 are sent.
- Collision: load_sw with sw=A5 in the same cycle as an accepted key 1C -> 1C is queued first, A5 the next cycle; sent order is 1C, A5.
- Overflow: hold tx_busy=1, queue DEPTH+2 distinct keys -> fifo_count=16 and overflow=1. Release busy -> the first 16 keys are sent in order. clr_ovf -> overflow=0.
- Simultaneous push/pop at full: FIFO full and a pop in the same cycle as a key write -> count stays 16, no overflow, and the new key is sent last.
- ACK timeout and reset: tx_busy stuck at 0 -> tx_start repeats every ACK_TIMEOUT+2 cycles until the FIFO is empty. Assert rst_n=0 mid-ACK -> all outputs at reset values on the same edge.

Source files
------------

// File: rtl/key_tx_queue_if.sv
// key_tx_queue_if: byte handshake between the key/switch queue and the UART TX.
//   tx_data  : byte presented to the transmitter, stable until the next pop
//   tx_start : one-cycle send request
//   tx_busy  : transmitter busy, driven by the UART
// Modports: master = queue side, slave = UART side.
interface key_tx_queue_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/key_tx_queue.sv
// key_tx_queue: buffered byte source for the UART transmitter.
// PS2 make codes (break sequences filtered, extended prefix optional) and
// button-loaded switch bytes are merged into a DEPTH-entry FIFO and drained
// through a start/busy handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   scancode, new_code  : PS2 byte and its one-cycle strobe
//   sw, load_sw         : switch byte and its single-pulsed load
//   clr_ovf             : synchronous clear of the overflow flag
//   tx                  : UART handshake (tx_data, tx_start, tx_busy)
//   last_key            : most recent accepted make code
//   fifo_count          : registered occupancy, 0..DEPTH
//   overflow            : sticky, a byte was dropped on a full FIFO
module key_tx_queue #(
  parameter int               DATA_W      = 8,
  parameter int               DEPTH       = 16,
  parameter logic [DATA_W-1:0] BREAK_CODE = 8'hF0,
  parameter logic [DATA_W-1:0] EXT_CODE   = 8'hE0,
  parameter bit               KEEP_EXT    = 1'b0,
  parameter int               ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        scancode,
  input  logic                     new_code,
  input  logic [DATA_W-1:0]        sw,
  input  logic                     load_sw,
  input  logic                     clr_ovf,
  key_tx_queue_if.master           tx,
  output logic [DATA_W-1:0]        last_key,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              skip;
  logic              pend;
  logic [DATA_W-1:0] pend_data;
  logic [TW-1:0]     ack_timer;

  logic              key_wr;
  logic              sw_wr;
  logic              wr;
  logic              full;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] wr_byte;

  always_comb begin
    key_wr = 1'b0;
    if (new_code && scancode != BREAK_CODE && !skip &&
        !(scancode == EXT_CODE && !KEEP_EXT))
      key_wr = 1'b1;
    // A pending switch byte yields to a key write in the same cycle.
    sw_wr   = pend && !key_wr;
    wr      = key_wr || sw_wr;
    wr_byte = key_wr ? scancode : pend_data;
    full    = (fifo_count == CW'(DEPTH));
    pop     = (state == IDLE) && (fifo_count != '0) && !tx.tx_busy;
    // A pop frees the slot the write needs, so full is not a drop then.
    push    = wr && (!full || pop);
  end

  // Filter state, switch pending register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip      <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      last_key  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (new_code) begin
        if (scancode == BREAK_CODE) skip <= 1'b1;
        else if (skip)              skip <= 1'b0;
      end
      if (key_wr) last_key <= scancode;
      if (load_sw) begin
        pend      <= 1'b1;
        pend_data <= sw;
      end else if (sw_wr) begin
        pend <= 1'b0;
      end
      if (wr && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)       overflow <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_byte;
  end

  // TX handshake. A missing busy response is tolerated: after ACK_TIMEOUT
  // cycles following tx_start the byte is treated as sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx.tx_start <= 1'b0;
      tx.tx_data  <= '0;
      ack_timer   <= '0;
    end else begin
      tx.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx.tx_data  <= mem[rd_ptr];
            tx.tx_start <= 1'b1;
            ack_timer   <= '0;
            state       <= ACK;
          end
        end
        ACK: begin
          if (tx.tx_busy)                         state     <= DONE;
          else if (ack_timer == TW'(ACK_TIMEOUT)) state     <= IDLE;
          else                                    ack_timer <= ack_timer + TW'(1);
        end
        DONE: begin
          if (!tx.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_tx_queue.sv
// tb_key_tx_queue: directed bench for key_tx_queue. dut0 (KEEP_EXT=0) is
// tracked every cycle by a queue-based model; dut1 (KEEP_EXT=1, busy tied
// low) is only checked on its sent byte sequence.
module tb_key_tx_queue;
  localparam int DEPTH = 16;
  localparam int TMO   = 15;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scancode = '0;
  logic [7:0] sw = '0;
  logic       new_code = 1'b0;
  logic       load_sw = 1'b0;
  logic       clr_ovf = 1'b0;

  logic [7:0] last_key0, last_key1;
  logic [4:0] fifo_count0, fifo_count1;
  logic       overflow0, overflow1;

  always #5 clk = ~clk;

  key_tx_queue_if #(.DATA_W(8)) ifc0 ();
  key_tx_queue_if #(.DATA_W(8)) ifc1 ();

  assign ifc1.tx_busy = 1'b0;

  key_tx_queue #(.DATA_W(8), .DEPTH(DEPTH), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0),
                 .KEEP_EXT(1'b0), .ACK_TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .scancode(scancode), .new_code(new_code),
    .sw(sw), .load_sw(load_sw), .clr_ovf(clr_ovf), .tx(ifc0),
    .last_key(last_key0), .fifo_count(fifo_count0), .overflow(overflow0));

  key_tx_queue #(.DATA_W(8), .DEPTH(DEPTH), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0),
                 .KEEP_EXT(1'b1), .ACK_TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .scancode(scancode), .new_code(new_code),
    .sw(sw), .load_sw(load_sw), .clr_ovf(clr_ovf), .tx(ifc1),
    .last_key(last_key1), .fifo_count(fifo_count1), .overflow(overflow1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input bq_t act, input bq_t exp);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < act.size()) chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // UART model: 10 busy cycles per tx_start (mode 0), or forced 1 / 0.
  int bmode = 0;
  int bcnt  = 0;
  always @(negedge clk) begin
    #1;
    case (bmode)
      0: begin
        if (ifc0.tx_start) bcnt = 10;
        else if (bcnt > 0) bcnt = bcnt - 1;
        ifc0.tx_busy = (bcnt > 0);
      end
      1:       ifc0.tx_busy = 1'b1;
      default: ifc0.tx_busy = 1'b0;
    endcase
  end

  // Reference model of dut0: byte queue plus transmit phase.
  logic [7:0] mq[$];
  bit         m_skip, m_pend, m_ovf, m_txs;
  logic [7:0] m_pd, m_last, m_txd, m_wb;
  int         m_phase, m_age, m_occ;
  bit         m_pop, m_key, m_sw, m_novf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_skip = 0; m_pend = 0; m_ovf = 0; m_txs = 0;
      m_pd = 0; m_last = 0; m_txd = 0; m_phase = 0; m_age = 0;
    end else begin
      m_occ = mq.size();
      m_pop = (m_phase == 0) && (m_occ > 0) && !ifc0.tx_busy;
      m_key = 0;
      if (new_code) begin
        if (scancode == 8'hF0)      m_skip = 1;
        else if (m_skip)            m_skip = 0;
        else if (scancode != 8'hE0) m_key = 1;
      end
      m_sw   = m_pend && !m_key;
      m_wb   = m_key ? scancode : m_pd;
      m_novf = 0;
      if (m_pop) begin
        m_txd = mq.pop_front();
        m_txs = 1;
        m_phase = 1;
        m_age = 0;
      end else begin
        m_txs = 0;
        if (m_phase == 1) begin
          if (ifc0.tx_busy)     m_phase = 2;
          else if (m_age == TMO) m_phase = 0;
          else                   m_age++;
        end else if (m_phase == 2 && !ifc0.tx_busy) begin
          m_phase = 0;
        end
      end
      if (m_key || m_sw) begin
        if (m_occ < DEPTH || m_pop) mq.push_back(m_wb);
        else m_novf = 1;
      end
      if (m_novf)       m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (m_key) m_last = scancode;
      if (load_sw) begin m_pend = 1; m_pd = sw; end
      else if (m_sw) m_pend = 0;
    end
  end

  // Per-cycle compare and send logging.
  int   cyc = 0;
  bq_t  sent0, sent1;
  int   stamp0[$];
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("fifo_count", fifo_count0, mq.size());
      chk("overflow", overflow0, m_ovf);
      chk("last_key", last_key0, m_last);
      chk("tx_start", ifc0.tx_start, m_txs);
      chk("tx_data", ifc0.tx_data, m_txd);
      if (ifc0.tx_start) begin
        sent0.push_back(ifc0.tx_data);
        stamp0.push_back(cyc);
      end
      if (ifc1.tx_start) sent1.push_back(ifc1.tx_data);
    end
  end

  task automatic drive(input bit nc, input logic [7:0] sc, input bit ls,
                       input logic [7:0] s, input bit clr);
    @(negedge clk);
    new_code = nc; scancode = sc; load_sw = ls; sw = s; clr_ovf = clr;
  endtask

  task automatic key(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t exp;
    bit  seen;
    repeat (3) @(negedge clk);
    chk("rst_fifo_count", fifo_count0, 0);
    chk("rst_tx_start", ifc0.tx_start, 0);
    chk("rst_tx_data", ifc0.tx_data, 0);
    chk("rst_last_key", last_key0, 0);
    chk("rst_overflow", overflow0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Make/break filtering.
    sent0.delete();
    key(8'h1C); key(8'hF0); key(8'h1C); key(8'h32);
    idle(50);
    exp = '{8'h1C, 8'h32};
    chk_seq("make_break", sent0, exp);
    chk("make_break_last_key", last_key0, 8'h32);
    chk("make_break_count", fifo_count0, 0);

    // Extended prefix, dropped on dut0 and kept on dut1.
    sent0.delete(); sent1.delete();
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    idle(80);
    exp = '{8'h75};
    chk_seq("ext_drop", sent0, exp);
    exp = '{8'hE0, 8'h75, 8'hE0};
    chk_seq("ext_keep", sent1, exp);

    // Key and switch load in the same cycle.
    sent0.delete();
    drive(1'b1, 8'h1C, 1'b1, 8'hA5, 1'b0);
    idle(50);
    exp = '{8'h1C, 8'hA5};
    chk_seq("collision", sent0, exp);

    // Overflow with the transmitter held busy.
    bmode = 1;
    idle(3);
    sent0.delete();
    for (int i = 0; i < DEPTH + 2; i++) key(8'h10 + 8'(i));
    idle(1);
    chk("full_count", fifo_count0, 16);
    chk("full_overflow", overflow0, 1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1);
    chk("clr_overflow", overflow0, 0);
    // Release busy while writing: pop and push on a full FIFO together.
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    bmode = 0;
    idle(1);
    chk("pushpop_count", fifo_count0, 16);
    chk("pushpop_overflow", overflow0, 0);
    idle(300);
    exp = {};
    for (int i = 0; i < DEPTH; i++) exp.push_back(8'h10 + 8'(i));
    exp.push_back(8'h55);
    chk_seq("drain_order", sent0, exp);

    // ACK timeout with busy stuck low.
    bmode = 2;
    idle(2);
    sent0.delete(); stamp0.delete();
    key(8'h41); key(8'h42); key(8'h43);
    idle(70);
    exp = '{8'h41, 8'h42, 8'h43};
    chk_seq("timeout_seq", sent0, exp);
    if (stamp0.size() >= 3) begin
      chk("timeout_period_a", stamp0[1] - stamp0[0], TMO + 2);
      chk("timeout_period_b", stamp0[2] - stamp0[1], TMO + 2);
    end

    // Reset while waiting for the acknowledge.
    sent0.delete();
    key(8'h44); key(8'h45); key(8'h46);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1);
      #1;
      seen = (sent0.size() > 0);
    end
    chk("ack_wait", seen, 1);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fifo_count", fifo_count0, 0);
    chk("mid_rst_tx_start", ifc0.tx_start, 0);
    chk("mid_rst_tx_data", ifc0.tx_data, 0);
    chk("mid_rst_last_key", last_key0, 0);
    chk("mid_rst_overflow", overflow0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("post_rst_count", fifo_count0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
